// File: rtl/router_pkg.sv
// Shared router constants and the arbiter state encoding.
package router_pkg;
   parameter int FLIT_W   = 55;
   parameter int N_REQ    = 4;
   parameter int TIMEOUT  = 16;
   parameter int TAIL_BIT = FLIT_W - 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit searching upward from token,
// wrapping modulo N.
module rr_pick #(
   parameter int N    = 4,
   parameter int TW   = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [TW-1:0] token,
   output logic [N-1:0]  pick,
   output logic          any
);

   int idx;

   always_comb begin
      pick = '0;
      idx  = 0;
      any  = |req;
      // Walk offsets from far to near so the nearest requester is the last writer.
      for (int off = N - 1; off >= 0; off--) begin
         idx = (int'(token) + off) % N;
         if (req[idx]) begin
            pick      = '0;
            pick[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/token_arbiter.sv
// Packet-atomic round-robin arbiter: locks one input buffer until its tail flit
// is transferred or the stall timeout forces a release.
module token_arbiter
   import router_pkg::state_t;
   import router_pkg::IDLE;
   import router_pkg::LOCKED;
#(
   parameter  int N_REQ   = router_pkg::N_REQ,
   parameter  int FLIT_W  = router_pkg::FLIT_W,
   parameter  int TIMEOUT = router_pkg::TIMEOUT,
   localparam int TOK_W   = $clog2(N_REQ),
   localparam int SC_W    = $clog2(TIMEOUT + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*FLIT_W-1:0]   flit_in,
   input  logic                      out_ready,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          grant,
   output logic [FLIT_W-1:0]         out_flit,
   output logic                      out_valid,
   output logic [TOK_W-1:0]          token,
   output logic                      timeout_err,
   output state_t                    state_dbg
);

   // Handshake: a flit moves when the buffer holding the grant asserts req and
   // out_ready is high in the same LOCKED cycle; ack is the pop strobe for it.

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    pick;
   logic                pick_any;
   logic [TOK_W-1:0]    gidx;
   logic [TOK_W-1:0]    tok_nxt;
   logic [FLIT_W-1:0]   gflit;
   logic                xfer;
   logic                rel_tail;
   logic                rel_to;
   logic [SC_W-1:0]     stall_q;

   rr_pick #(.N(N_REQ), .TW(TOK_W)) u_pick (
      .req   (req),
      .token (token),
      .pick  (pick),
      .any   (pick_any)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) gidx = TOK_W'(i);
      end
   end

   assign gflit    = flit_in[int'(gidx)*FLIT_W +: FLIT_W];
   assign xfer     = (state_q == LOCKED) && |(req & grant) && out_ready && !rst;
   assign rel_tail = xfer && gflit[FLIT_W-1];
   assign rel_to   = (state_q == LOCKED) && !xfer && (stall_q == SC_W'(TIMEOUT - 1));
   assign tok_nxt  = (gidx == TOK_W'(N_REQ - 1)) ? '0 : gidx + TOK_W'(1);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = LOCKED;
         LOCKED:  if (rel_tail || rel_to) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack       = xfer ? grant : '0;
      state_dbg = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant       <= '0;
         token       <= '0;
         out_flit    <= '0;
         out_valid   <= 1'b0;
         timeout_err <= 1'b0;
         stall_q     <= '0;
      end else begin
         out_valid   <= xfer;
         timeout_err <= rel_to;
         if (xfer) out_flit <= gflit;
         if (state_q == IDLE) begin
            if (pick_any) begin
               grant   <= pick;
               stall_q <= '0;
            end
         end else if (rel_tail || rel_to) begin
            grant   <= '0;
            token   <= tok_nxt;
            stall_q <= '0;
         end else if (xfer) begin
            stall_q <= '0;
         end else begin
            stall_q <= stall_q + SC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_token_arbiter.sv
// Directed bench for token_arbiter: packet-level reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_token_arbiter;

   localparam int N  = 4;
   localparam int FW = 55;
   localparam int TO = 16;
   localparam logic [FW-1:0] TAIL = {1'b1, {(FW-1){1'b0}}};

   logic                  clk;
   logic                  rst;
   logic [N-1:0]          req;
   logic [N*FW-1:0]       flit_in;
   logic                  out_ready;
   logic [N-1:0]          ack;
   logic [N-1:0]          grant;
   logic [FW-1:0]         out_flit;
   logic                  out_valid;
   logic [1:0]            token;
   logic                  timeout_err;
   router_pkg::state_t    state_dbg;

   token_arbiter #(.N_REQ(N), .FLIT_W(FW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .flit_in     (flit_in),
      .out_ready   (out_ready),
      .ack         (ack),
      .grant       (grant),
      .out_flit    (out_flit),
      .out_valid   (out_valid),
      .token       (token),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: owner index (-1 = nobody), token, stalled-cycle count.
   int             m_owner = -1;
   int             m_token = 0;
   int             m_stall = 0;
   bit             m_ov    = 1'b0;
   bit             m_terr  = 1'b0;
   logic [FW-1:0]  m_flit  = '0;
   bit             chk_en  = 1'b0;

   function automatic int rr_first(input logic [N-1:0] r, input int t);
      for (int off = 0; off < N; off++) begin
         if (r[(t + off) % N]) return (t + off) % N;
      end
      return -1;
   endfunction

   function automatic bit model_xfer();
      return !rst && m_owner >= 0 && req[m_owner] && out_ready;
   endfunction

   always @(posedge clk) begin
      logic [FW-1:0] f;
      bit x;
      if (rst) begin
         m_owner = -1; m_token = 0; m_stall = 0;
         m_ov = 0; m_terr = 0; m_flit = '0;
      end else begin
         x      = model_xfer();
         m_ov   = x;
         m_terr = 0;
         if (m_owner < 0) begin
            if (req != 0) begin
               m_owner = rr_first(req, m_token);
               m_stall = 0;
            end
         end else if (x) begin
            f       = flit_in[m_owner*FW +: FW];
            m_flit  = f;
            m_stall = 0;
            if (f[FW-1]) begin
               m_token = (m_owner + 1) % N;
               m_owner = -1;
            end
         end else if (m_stall == TO - 1) begin
            m_terr  = 1;
            m_token = (m_owner + 1) % N;
            m_owner = -1;
            m_stall = 0;
         end else begin
            m_stall++;
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0] eg;
      if (chk_en) begin
         eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
         chk("grant", 64'(grant), 64'(eg));
         chk("ack", 64'(ack), model_xfer() ? 64'(eg) : 64'(0));
         chk("token", 64'(token), 64'(m_token));
         chk("out_valid", 64'(out_valid), 64'(m_ov));
         chk("out_flit", 64'(out_flit), 64'(m_flit));
         chk("timeout_err", 64'(timeout_err), 64'(m_terr));
         chk("state", 64'(state_dbg), (m_owner < 0) ? 64'(0) : 64'(1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [FW-1:0] v);
      flit_in[i*FW +: FW] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '1; flit_in = '0; out_ready = 1'b1;
      step(); step();
      chk_en = 1'b1;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_token", 64'(token), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));

      // Single three-flit packet from buffer 2.
      rst = 1'b0; req = 4'b0100; put(2, 55'd100);
      step();
      chk("pkt_grant", 64'(grant), 64'(4'b0100));
      chk("pkt_ack", 64'(ack), 64'(4'b0100));
      step();
      chk("pkt_flit0", 64'(out_flit), 64'(100));
      chk("pkt_valid0", 64'(out_valid), 64'(1));
      put(2, 55'd50);
      step();
      chk("pkt_flit1", 64'(out_flit), 64'(50));
      put(2, TAIL | 55'd42);
      step();
      chk("pkt_flit2", 64'(out_flit), 64'(TAIL | 55'd42));
      chk("pkt_release", 64'(grant), 64'(0));
      chk("pkt_token", 64'(token), 64'(3));
      req = '0;
      step();
      chk("pkt_idle_valid", 64'(out_valid), 64'(0));

      // Round robin over single-flit packets.
      do_reset();
      req = '1;
      for (int k = 0; k < N; k++) put(k, TAIL | FW'(k));
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_grant", 64'(grant), 64'(N'(1) << (k % N)));
         step();
         chk("rr_gap", 64'(grant), 64'(0));
      end
      req = '0;
      step();

      // Backpressure mid-packet on buffer 1.
      do_reset();
      req = 4'b0010; put(1, 55'd11);
      step();
      chk("bp_grant", 64'(grant), 64'(4'b0010));
      step();
      chk("bp_flit0", 64'(out_flit), 64'(11));
      out_ready = 1'b0; put(1, 55'd22);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ack", 64'(ack), 64'(0));
         step();
         chk("bp_valid", 64'(out_valid), 64'(0));
         chk("bp_hold", 64'(grant), 64'(4'b0010));
      end
      out_ready = 1'b1;
      step();
      chk("bp_flit1", 64'(out_flit), 64'(22));
      chk("bp_valid1", 64'(out_valid), 64'(1));
      put(1, TAIL | 55'd33);
      step();
      chk("bp_flit2", 64'(out_flit), 64'(TAIL | 55'd33));
      chk("bp_token", 64'(token), 64'(2));
      req = '0;
      step();

      // Timeout: buffer 2 drops its request mid-packet.
      do_reset();
      req = 4'b0100;
      step();
      chk("to_grant", 64'(grant), 64'(4'b0100));
      req = 4'b0001; put(0, TAIL | 55'd7);
      for (int k = 0; k < TO - 1; k++) step();
      chk("to_pre_err", 64'(timeout_err), 64'(0));
      chk("to_pre_grant", 64'(grant), 64'(4'b0100));
      step();
      chk("to_err", 64'(timeout_err), 64'(1));
      chk("to_release", 64'(grant), 64'(0));
      chk("to_token", 64'(token), 64'(3));
      step();
      chk("to_err_pulse", 64'(timeout_err), 64'(0));
      chk("to_regrant", 64'(grant), 64'(4'b0001));
      step();
      chk("to_flit", 64'(out_flit), 64'(TAIL | 55'd7));
      chk("to_token2", 64'(token), 64'(1));
      req = '0;
      step();

      // Reset in the middle of a buffer 0 packet.
      do_reset();
      req = 4'b0001; put(0, 55'd1);
      step();
      chk("mr_grant", 64'(grant), 64'(4'b0001));
      step();
      put(0, 55'd2);
      step();
      chk("mr_flit1", 64'(out_flit), 64'(2));
      put(0, TAIL | 55'd3); rst = 1'b1;
      #1;
      chk("mr_ack_rst", 64'(ack), 64'(0));
      step();
      chk("mr_grant0", 64'(grant), 64'(0));
      chk("mr_token0", 64'(token), 64'(0));
      chk("mr_valid0", 64'(out_valid), 64'(0));
      chk("mr_flit0", 64'(out_flit), 64'(0));
      rst = 1'b0; req = 4'b0011;
      step();
      chk("mr_fresh", 64'(grant), 64'(4'b0001));
      step();
      chk("mr_token1", 64'(token), 64'(1));
      req = '0;
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/token_arbiter.md
TOKEN_ARBITER -- requirements
Module: token_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesting input buffers.
REQ-002 Parameter FLIT_W, default 55, flit width matching router buffer width; bit FLIT_W-1 is the tail flag.
REQ-003 Parameter TIMEOUT, default 16, stalled-cycle limit before a locked grant is forcibly released.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N_REQ  per-buffer request; bit i high means buffer i presents a valid flit.
REQ-007 flit_in  input  N_REQ*FLIT_W  concatenated flits; slice i is [i*FLIT_W +: FLIT_W].
REQ-008 out_ready  input  1  downstream can accept a flit this cycle.
REQ-009 ack  output  N_REQ  combinational one-hot pop strobe to the granted buffer.
REQ-010 grant  output  N_REQ  registered one-hot current owner; all-zero when idle.
REQ-011 out_flit  output  FLIT_W  registered transferred flit.
REQ-012 out_valid  output  1  registered; high the cycle after a transfer.
REQ-013 token  output  log2(N_REQ)  registered round-robin priority pointer.
REQ-014 timeout_err  output  1  registered one-cycle pulse on forced release.

Function
REQ-015 State machine SHALL have two states: IDLE (no owner) and LOCKED (grant held by one buffer).
REQ-016 IDLE with req != 0: next edge SHALL enter LOCKED with grant = first set req bit searching upward from token, wrapping modulo N_REQ.
REQ-017 IDLE with req == 0: SHALL remain IDLE; grant stays 0.
REQ-018 Transfer SHALL occur in a cycle where state is LOCKED, req[g] = 1 and out_ready = 1 (g = granted index); only then ack[g] = 1 in that same cycle.
REQ-019 ack SHALL be all-zero in IDLE and in any LOCKED cycle without a transfer.
REQ-020 On transfer, next edge SHALL load out_flit with flit_in slice g and set out_valid = 1; otherwise out_valid = 0 and out_flit holds.
REQ-021 Transfer of a flit with tail bit = 1 SHALL return to IDLE at next edge, clear grant, and set token = (g+1) mod N_REQ.
REQ-022 Non-tail transfers SHALL keep LOCKED and grant unchanged (packet is never interleaved).
REQ-023 Stall counter SHALL increment each LOCKED cycle without transfer, clear on transfer or on entering LOCKED, and saturate never past TIMEOUT-1.
REQ-024 When stall counter equals TIMEOUT-1 and no transfer occurs that cycle, next edge SHALL go IDLE, clear grant, set token = (g+1) mod N_REQ, pulse timeout_err for one cycle.
REQ-025 Transfer in the same cycle the counter reaches TIMEOUT-1 SHALL take precedence; no error.
REQ-026 Requests from non-granted buffers while LOCKED SHALL be ignored; no ack to them.
REQ-027 Token SHALL change only on tail release or timeout release.
REQ-028 Re-arbitration from IDLE costs one cycle; max throughput one flit per cycle within a packet.

Reset
REQ-029 When rst = 1 at a rising edge: state = IDLE, grant = 0, token = 0, out_flit = 0, out_valid = 0, timeout_err = 0, stall counter = 0.
REQ-030 Reset SHALL override any in-progress packet, including a transfer in the same cycle; ack SHALL be 0 while rst = 1.

Structure
REQ-031 Shared package router_pkg SHALL hold FLIT_W, N_REQ, TAIL_BIT index and the IDLE/LOCKED state encoding.
REQ-032 Sub-module rr_pick (combinational rotating priority encoder: req, token -> one-hot, any) SHALL implement REQ-016.

Verification
REQ-033 Reset: rst = 1 two cycles with req = 4'b1111 -> grant 0, ack 0, token 0, out_valid 0.
REQ-034 Single packet: req = 4'b0100, flits 55'd100, 55'd50, tail|55'd42, out_ready = 1 -> grant 4'b0100 one cycle after req, out_flit 100/50/tail|42 on consecutive cycles, then IDLE, token = 3.
REQ-035 Round robin: req = 4'b1111, all single tail flits, token 0 -> grants in order 0,1,2,3,0, each separated by one idle cycle.
REQ-036 Backpressure: locked on buffer 1, out_ready = 0 for 5 cycles mid-packet -> ack 0, out_valid 0, grant held, packet resumes unchanged when out_ready = 1.
REQ-037 Timeout: locked on buffer 2, req[2] dropped with no tail for 16 cycles -> timeout_err pulse one cycle, grant 0, token = 3; other requester then granted.
REQ-038 Mid-packet reset: rst = 1 after second flit of buffer 0 packet -> next edge IDLE, token 0, out_valid 0; re-arbitration starts fresh.
